skew_feeder: RTL and testbench
==============================

SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 DATA_WIDTH, 8, bit width of one memory element and one feed lane.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one skewed feed pass; sampled only in IDLE.
REQ-005 stall  input  1  freeze step counter for the current cycle; no read issued.
REQ-006 mem_read_enable  output  4  per-line read enable to the 4x4 operand memory.
REQ-007 mem_read_elem  output  8  per-line element select; line i at bits [2i+1:2i].
REQ-008 mem_data_out  input  4*DATA_WIDTH  asynchronous memory read data; line i at bits [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i], zero when that line is disabled.
REQ-009 feed_data  output  4*DATA_WIDTH  registered skewed lane data to the systolic array, same lane packing.
REQ-010 feed_valid  output  4  registered per-lane valid.
REQ-011 busy  output  1  high while in FEED.
REQ-012 done  output  1  one-cycle pulse marking the final feed beat.

Function
REQ-013 The FSM SHALL have states IDLE, FEED and DONE, with a 3-bit step counter t.
REQ-014 IDLE: start=1 at an edge SHALL move to FEED with t=0; otherwise the FSM SHALL stay in IDLE.
REQ-015 FEED with stall=0: step t SHALL be issued, t increments, and after t=6 the FSM SHALL move to DONE.
REQ-016 FEED with stall=1: t SHALL hold, no read SHALL be issued, and the FSM SHALL stay in FEED.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE; stall and start SHALL be ignored in DONE.
REQ-018 start SHALL be ignored in FEED and DONE; no queuing.
REQ-019 mem_read_enable and mem_read_elem SHALL be combinational from state, t and stall.
REQ-020 Issuing step t: mem_read_enable[i]=1 iff i<=t<=i+3, and then mem_read_elem[i]=t-i (2-bit).
REQ-021 Any disabled line, and every line outside an issued step (IDLE, DONE, stalled), SHALL drive enable 0 and elem 0.
REQ-022 At every edge, feed_data SHALL register mem_data_out and feed_valid SHALL register mem_read_enable, giving 1-cycle latency from issue to output.
REQ-023 A non-issue cycle SHALL therefore produce feed_valid=0000 and feed_data=0 on the following cycle.
REQ-024 busy SHALL be 1 exactly while the state is FEED.
REQ-025 done SHALL be 1 exactly while the state is DONE, coinciding with the final beat feed_valid=1000.
REQ-026 An unstalled pass SHALL be 7 busy cycles and 1 done cycle; each stalled cycle adds one busy cycle.
REQ-027 Stall in IDLE SHALL have no effect.
REQ-028 The block SHALL require memory contents to be held stable by the system during FEED; it does not check this.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, t=0, feed_data=0, feed_valid=0, busy=0 and done=0.
REQ-030 While rst_n is low, mem_read_enable SHALL be 0 and mem_read_elem SHALL be 0.
REQ-031 Reset mid-pass SHALL abort the pass with no done pulse.
REQ-032 After rst_n releases, the block SHALL stay idle until the next sampled start.

Verification
REQ-033 Reset scenario: assert rst_n low at any time -> all outputs 0 within the same cycle, with no clock edge required.
REQ-034 Full pass: load mem[l][e]=0x(l)(e) and pulse start one cycle -> feed_valid sequence 0001,0011,0111,1111,1110,1100,1000 on consecutive cycles.
  - Lane i on beat t SHALL carry 0x(i)(t-i), e.g. beat 3 = {0x30,0x21,0x12,0x03}.
  - done=1 only on the 1000 beat; busy=1 for 7 cycles.
REQ-035 Stall scenario: stall=1 for 2 cycles while t=3 -> two feed_valid=0000 bubbles after beat 2, then beats 3..6 unchanged; busy=1 for 9 cycles.
REQ-036 Back-to-back scenario: hold start=1 continuously -> passes repeat, separated by one DONE cycle plus one IDLE cycle; a start pulse issued mid-FEED produces no extra pass.
REQ-037 Abort scenario: rst_n low during beat 4 -> outputs cleared at once with no done pulse; start after release -> a complete, correct 7-beat pass.
REQ-038 Read-address check: on every cycle, mem_read_elem equals 0 for each line with mem_read_enable=0, and line i elem equals t-i otherwise.

Source files
------------

// File: rtl/skew_feeder.sv
// skew_feeder: drives a 4x4 operand memory with a diagonally skewed read
// pattern and registers the returned lanes toward a 4-lane systolic array.
// One pass issues steps t=0..6. Line i is active for t in [i, i+3] and reads
// element t-i. This produces the wavefront 0001,0011,0111,1111,1110,1100,1000.
module skew_feeder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stall,
    output logic [3:0]              mem_read_enable,
    output logic [7:0]              mem_read_elem,
    input  logic [4*DATA_WIDTH-1:0] mem_data_out,
    output logic [4*DATA_WIDTH-1:0] feed_data,
    output logic [3:0]              feed_valid,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd6;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              t;
    logic [2:0]              t_next;
    logic                    issue;
    logic [4*DATA_WIDTH-1:0] data_gated;

    // State and step counter registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= 3'd0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, stall only freezes FEED.
    always_comb begin
        state_next = state;
        t_next     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FEED;
                    t_next     = 3'd0;
                end
            end
            FEED: begin
                if (!stall) begin
                    if (t == LAST_STEP) begin
                        state_next = DONE;
                        t_next     = 3'd0;
                    end else begin
                        t_next = t + 3'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                t_next     = 3'd0;
            end
            default: begin
                state_next = IDLE;
                t_next     = 3'd0;
            end
        endcase
    end

    // A step is issued only on an unstalled FEED cycle.
    assign issue = (state == FEED) && !stall;

    // Skewed read addressing: line i is live while i <= t <= i+3, reading t-i.
    always_comb begin
        mem_read_enable = 4'b0000;
        mem_read_elem   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (issue && (t >= 3'(i)) && (t <= 3'(i) + 3'd3)) begin
                mem_read_enable[i]     = 1'b1;
                mem_read_elem[2*i +: 2] = 2'(t - 3'(i));
            end
        end
    end

    // Mask lanes that were not read so a memory that leaves stale data on a
    // disabled line still produces clean zeros toward the array.
    always_comb begin
        data_gated = '0;
        for (int i = 0; i < 4; i++) begin
            if (mem_read_enable[i]) begin
                data_gated[DATA_WIDTH*i +: DATA_WIDTH] = mem_data_out[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Output stage: one cycle from issue to the lanes seen by the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feed_data  <= '0;
            feed_valid <= 4'b0000;
        end else begin
            feed_data  <= data_gated;
            feed_valid <= mem_read_enable;
        end
    end

    // Status flags decode straight from the state register.
    assign busy = (state == FEED);
    assign done = (state == DONE);

endmodule

// File: tb/tb_skew_feeder.sv
// Testbench for skew_feeder: a memory model holding mem[l][e] = 0x(l)(e),
// a per-cycle vector table for the full, stalled and back-to-back passes, and
// a hand-written mid-pass reset abort followed by a clean pass.
module tb_skew_feeder;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stall;
    logic [3:0]    mem_read_enable;
    logic [7:0]    mem_read_elem;
    logic [4*DW-1:0] mem_data_out;
    logic [4*DW-1:0] feed_data;
    logic [3:0]    feed_valid;
    logic          busy;
    logic          done;

    typedef struct {
        logic start;
        logic stall;
        logic exp_busy;
        logic exp_done;
        int   beat;
    } vec_t;

    typedef struct {
        logic        busy;
        logic        done;
        logic [3:0]  valid;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [7:0] mem [4][4];
    logic [3:0] valid_pat [7];

    int checks = 0;
    int errors = 0;
    int fp_start;

    skew_feeder #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stall           (stall),
        .mem_read_enable (mem_read_enable),
        .mem_read_elem   (mem_read_elem),
        .mem_data_out    (mem_data_out),
        .feed_data       (feed_data),
        .feed_valid      (feed_valid),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Asynchronous operand memory; disabled lines return zero.
    always_comb begin
        mem_data_out = '0;
        for (int l = 0; l < 4; l++) begin
            if (mem_read_enable[l]) begin
                mem_data_out[DW*l +: DW] = mem[l][mem_read_elem[2*l +: 2]];
            end
        end
    end

    function automatic logic [3:0] exp_valid(int beat);
        if (beat < 0) return 4'b0000;
        return valid_pat[beat];
    endfunction

    function automatic logic [7:0] exp_elem(int beat);
        logic [7:0] e;
        logic [3:0] v;
        e = 8'h00;
        v = exp_valid(beat);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) e[2*i +: 2] = 2'(beat - i);
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_data(int beat);
        logic [31:0] d;
        logic [3:0]  v;
        d = 32'h0;
        v = exp_valid(beat);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) d[8*i +: 8] = {4'(i), 4'(beat - i)};
        end
        return d;
    endfunction

    function automatic void add(logic s, logic st, logic b, logic d, int beat);
        vec_t v;
        v.start    = s;
        v.stall    = st;
        v.exp_busy = b;
        v.exp_done = d;
        v.beat     = beat;
        vecs.push_back(v);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs, check the read address it issues, queue the
    // expected registered result and advance past the clock edge.
    task automatic applyStimulus(vec_t v, int idx);
        exp_t e;
        start = v.start;
        stall = v.stall;
        #1;
        cmp($sformatf("v%0d read_enable", idx), 32'(mem_read_enable), 32'(exp_valid(v.beat)));
        cmp($sformatf("v%0d read_elem", idx), 32'(mem_read_elem), 32'(exp_elem(v.beat)));
        e.busy  = v.exp_busy;
        e.done  = v.exp_done;
        e.valid = exp_valid(v.beat);
        e.data  = exp_data(v.beat);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(int idx);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL v%0d scoreboard: got empty queue expected entry", idx);
            return;
        end
        e = sb.pop_front();
        cmp($sformatf("v%0d busy", idx), 32'(busy), 32'(e.busy));
        cmp($sformatf("v%0d done", idx), 32'(done), 32'(e.done));
        cmp($sformatf("v%0d feed_valid", idx), 32'(feed_valid), 32'(e.valid));
        cmp($sformatf("v%0d feed_data", idx), feed_data, e.data);
    endtask

    task automatic checkAllZero(string tag);
        cmp({tag, " busy"}, 32'(busy), 32'h0);
        cmp({tag, " done"}, 32'(done), 32'h0);
        cmp({tag, " feed_valid"}, 32'(feed_valid), 32'h0);
        cmp({tag, " feed_data"}, feed_data, 32'h0);
        cmp({tag, " read_enable"}, 32'(mem_read_enable), 32'h0);
        cmp({tag, " read_elem"}, 32'(mem_read_elem), 32'h0);
    endtask

    initial begin
        valid_pat[0] = 4'b0001;
        valid_pat[1] = 4'b0011;
        valid_pat[2] = 4'b0111;
        valid_pat[3] = 4'b1111;
        valid_pat[4] = 4'b1110;
        valid_pat[5] = 4'b1100;
        valid_pat[6] = 4'b1000;
        for (int l = 0; l < 4; l++)
            for (int e = 0; e < 4; e++)
                mem[l][e] = {4'(l), 4'(e)};

        // Stall in IDLE has no effect.
        add(0, 1, 0, 0, -1);
        add(0, 1, 0, 0, -1);
        // Full pass; start mid-FEED and start/stall in DONE are ignored.
        fp_start = vecs.size();
        add(1, 0, 1, 0, -1);
        add(0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1);
        add(1, 0, 1, 0, 2);
        add(0, 0, 1, 0, 3);
        add(0, 0, 1, 0, 4);
        add(0, 0, 1, 0, 5);
        add(0, 0, 0, 1, 6);
        add(1, 1, 0, 0, -1);
        add(0, 0, 0, 0, -1);
        // Two stall cycles while t=3.
        add(1, 0, 1, 0, -1);
        add(0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 2);
        add(0, 1, 1, 0, -1);
        add(0, 1, 1, 0, -1);
        add(0, 0, 1, 0, 3);
        add(0, 0, 1, 0, 4);
        add(0, 0, 1, 0, 5);
        add(0, 0, 0, 1, 6);
        add(0, 1, 0, 0, -1);
        add(0, 1, 0, 0, -1);
        // start held high: passes separated by one DONE and one IDLE cycle.
        add(1, 0, 1, 0, -1);
        for (int b = 0; b < 6; b++) add(1, 0, 1, 0, b);
        add(1, 0, 0, 1, 6);
        add(1, 0, 0, 0, -1);
        add(1, 0, 1, 0, -1);
        for (int b = 0; b < 6; b++) add(1, 0, 1, 0, b);
        add(1, 0, 0, 1, 6);
        add(0, 0, 0, 0, -1);
        add(0, 0, 0, 0, -1);

        start = 1'b0;
        stall = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k], k);
            checkOutput(k);
        end

        // Abort: reset while beat 4 is on the lanes, between clock edges.
        for (int k = fp_start; k < fp_start + 6; k++) begin
            applyStimulus(vecs[k], k);
            checkOutput(k);
        end
        start = 1'b0;
        stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        repeat (2) begin
            @(posedge clk);
            #1;
            cmp("abort hold done", 32'(done), 32'h0);
            cmp("abort hold busy", 32'(busy), 32'h0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            cmp("post-release done", 32'(done), 32'h0);
            cmp("post-release busy", 32'(busy), 32'h0);
            cmp("post-release feed_valid", 32'(feed_valid), 32'h0);
        end
        for (int k = fp_start; k < fp_start + 10; k++) begin
            applyStimulus(vecs[k], 1000 + k);
            checkOutput(1000 + k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
